ex_mem_stage: RTL

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register built as a two-entry skid buffer with branch/jump
// resolution on accept. in_ready is a flop, so out_ready never reaches it combinationally.
module ex_mem_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] AluResult,
    input  logic         CarryFlag,
    input  logic         ZeroFlag,
    input  logic         OverflowFlag,
    input  logic         SignFlag,
    input  logic [N-1:0] StoreData,
    input  logic [N-1:0] PcTarget,
    input  logic [4:0]   Rd,
    input  logic [2:0]   Funct3,
    input  logic         Branch,
    input  logic         Jump,
    input  logic         RegWrite,
    input  logic         MemRead,
    input  logic         MemWrite,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_AluResult,
    output logic [N-1:0] out_StoreData,
    output logic [4:0]   out_Rd,
    output logic [2:0]   out_Funct3,
    output logic         out_RegWrite,
    output logic         out_MemRead,
    output logic         out_MemWrite,
    output logic         redirect,
    output logic [N-1:0] redirect_pc
);

    typedef struct packed {
        logic [N-1:0] alu;
        logic [N-1:0] store;
        logic [4:0]   rd;
        logic [2:0]   funct3;
        logic         regwrite;
        logic         memread;
        logic         memwrite;
    } entry_t;

    entry_t       r_main;
    entry_t       r_skid;
    logic         r_main_valid;
    logic         r_skid_valid;
    logic         r_in_ready;
    logic         r_redirect;
    logic [N-1:0] r_redirect_pc;

    entry_t       w_new;
    entry_t       w_main_nxt;
    entry_t       w_skid_nxt;
    logic         w_main_valid_nxt;
    logic         w_skid_valid_nxt;
    logic         w_redirect_nxt;
    logic [N-1:0] w_redirect_pc_nxt;
    logic         w_accept;
    logic         w_deliver;
    logic         w_taken;
    logic         w_redirect_take;

    assign w_accept  = in_valid & r_in_ready;
    assign w_deliver = r_main_valid & out_ready;

    always_comb begin
        w_taken = 1'b0;
        case (Funct3)
            3'b000:  w_taken = ZeroFlag;
            3'b001:  w_taken = ~ZeroFlag;
            3'b100:  w_taken = SignFlag ^ OverflowFlag;
            3'b101:  w_taken = ~(SignFlag ^ OverflowFlag);
            3'b110:  w_taken = ~CarryFlag;
            3'b111:  w_taken = CarryFlag;
            default: w_taken = 1'b0;
        endcase
    end

    assign w_redirect_take = Jump | (Branch & w_taken);

    // Branches never write back or touch memory, whatever the decoder drove.
    always_comb begin
        w_new.alu      = AluResult;
        w_new.store    = StoreData;
        w_new.rd       = Rd;
        w_new.funct3   = Funct3;
        w_new.regwrite = RegWrite & ~Branch;
        w_new.memread  = MemRead & ~Branch;
        w_new.memwrite = MemWrite & ~Branch;
    end

    always_comb begin
        w_main_nxt        = r_main;
        w_skid_nxt        = r_skid;
        w_main_valid_nxt  = r_main_valid;
        w_skid_valid_nxt  = r_skid_valid;
        w_redirect_nxt    = w_accept & w_redirect_take;
        w_redirect_pc_nxt = (w_accept & w_redirect_take) ? PcTarget : r_redirect_pc;

        if (flush) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
            w_redirect_nxt   = 1'b0;
            w_redirect_pc_nxt = r_redirect_pc;
        end else if (r_skid_valid) begin
            // in_ready is low here, so no accept can coincide with the skid drain
            if (w_deliver) begin
                w_main_nxt       = r_skid;
                w_skid_valid_nxt = 1'b0;
            end
        end else if (w_accept) begin
            if (!r_main_valid || w_deliver) begin
                w_main_nxt       = w_new;
                w_main_valid_nxt = 1'b1;
            end else begin
                w_skid_nxt       = w_new;
                w_skid_valid_nxt = 1'b1;
            end
        end else if (w_deliver) begin
            w_main_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_main        <= '0;
            r_skid        <= '0;
            r_main_valid  <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_in_ready    <= 1'b1;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_main        <= w_main_nxt;
            r_skid        <= w_skid_nxt;
            r_main_valid  <= w_main_valid_nxt;
            r_skid_valid  <= w_skid_valid_nxt;
            r_in_ready    <= ~w_skid_valid_nxt;
            r_redirect    <= w_redirect_nxt;
            r_redirect_pc <= w_redirect_pc_nxt;
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_main_valid;
    assign out_AluResult = r_main.alu;
    assign out_StoreData = r_main.store;
    assign out_Rd        = r_main.rd;
    assign out_Funct3    = r_main.funct3;
    assign out_RegWrite  = r_main.regwrite;
    assign out_MemRead   = r_main.memread;
    assign out_MemWrite  = r_main.memwrite;
    assign redirect      = r_redirect;
    assign redirect_pc   = r_redirect_pc;

endmodule
